// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter that shares one FIFO write port between
//            NUM_REQ requesters.  The winner owns the port for a tenure of
//            up to BURST_LEN writes.  The tenure ends early if the owner
//            drops its request.  Writes stall while the FIFO reports full.
//            At least one idle cycle always separates two tenures.
// Ports    : wr_clk     - write-domain clock (rising edge)
//            wr_rst     - asynchronous active-low reset
//            req        - per-requester level request
//            req_data   - packed write data, slice i belongs to requester i
//            fifo_full  - FIFO full flag (combinational, same domain)
//            gnt        - one-hot grant to the current owner, 0 when idle
//            req_ack    - one-hot pulse: owner's data word written this cycle
//            wr_en      - FIFO write enable
//            wr_data    - FIFO write data (0 when idle)
//            owner      - index of current owner, valid while busy
//            busy       - a tenure is in progress
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [2:0]                    owner,
    output logic                          busy
);

    localparam logic [0:0] c_idle      = 1'b0;
    localparam logic [0:0] c_own       = 1'b1;
    localparam logic [3:0] c_last_beat = 4'(BURST_LEN - 1);
    // Last owner resets to the top index so requester 0 wins the first search.
    localparam logic [2:0] c_init_last = 3'(NUM_REQ - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [2:0]            r_owner;
    logic [2:0]            r_last_owner;
    logic [3:0]            r_beat;
    logic [2:0]            w_sel;
    logic                  w_sel_vld;
    logic [NUM_REQ-1:0]    w_owner_oh;
    logic                  w_busy;
    logic                  w_owner_req;
    logic                  w_wr_en;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_wr_data;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner_oh
            assign w_owner_oh[gi] = (r_owner == 3'(gi));
        end
    endgenerate

    assign w_busy      = (r_state == c_own);
    assign w_owner_req = |(req & w_owner_oh);
    assign w_wr_en     = w_busy && w_owner_req && !fifo_full;
    // A tenure ends when the owner withdraws, or on the write of its last beat.
    assign w_release   = w_busy && (!w_owner_req || (w_wr_en && (r_beat == c_last_beat)));

    // Round-robin search: candidate k steps past the last owner, wrapping.
    always_comb begin
        w_sel     = 3'd0;
        w_sel_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_sel_vld && req[i] &&
                    (i == ((int'(r_last_owner) + k) % NUM_REQ))) begin
                    w_sel     = 3'(i);
                    w_sel_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_busy && w_owner_oh[i]) begin
                w_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_sel_vld) w_state_nxt = c_own;
            c_own:   if (w_release) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_owner      <= 3'd0;
            r_last_owner <= c_init_last;
            r_beat       <= 4'd0;
        end else begin
            if (!w_busy && w_sel_vld) begin
                r_owner <= w_sel;
                r_beat  <= 4'd0;
            end else if (w_wr_en) begin
                r_beat <= r_beat + 4'd1;
            end
            if (w_release) begin
                r_last_owner <= r_owner;
            end
        end
    end

    assign busy    = w_busy;
    assign owner   = r_owner;
    assign gnt     = w_busy ? w_owner_oh : '0;
    assign req_ack = w_wr_en ? w_owner_oh : '0;
    assign wr_en   = w_wr_en;
    assign wr_data = w_wr_data;

endmodule
`default_nettype wire
